// File: rtl/sdram_frame_buf_sched.sv
// -----------------------------------------------------------------------------
// sdram_frame_buf_sched
//   Triple-buffer frame scheduler for the 2-FIFO SDRAM frame store. Chooses
//   the slot the write stream fills and the slot the read stream displays, so
//   that the reader always gets the newest complete frame and the writer never
//   touches the slot being displayed.
//
// Ports
//   clk_ref          in   SDRAM reference clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   sdram_init_done  in   SDRAM initialisation complete (level)
//   frame_write_done in   1-cycle pulse, write stream finished a frame
//   frame_read_done  in   1-cycle pulse, read stream finished a frame
//   wr_addr/wr_max_addr/wr_load   write slot window and reload strobe
//   rd_addr/rd_max_addr/rd_load   read slot window and reload strobe
//   frame_valid      out  a complete frame exists since init
//   wr_slot/rd_slot  out  current write / read slot index (0..2)
//   drop_cnt         out  frames overwritten unread (saturating)
//   repeat_cnt       out  frames re-displayed (saturating)
// -----------------------------------------------------------------------------
module sdram_frame_buf_sched #(
  parameter logic [21:0] BASE_ADDR   = 22'd0,
  parameter logic [21:0] FRAME_SIZE  = 22'd307200,
  parameter int unsigned LOAD_CYCLES = 4
) (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  input  logic        frame_write_done,
  input  logic        frame_read_done,
  output logic [21:0] wr_addr,
  output logic [21:0] wr_max_addr,
  output logic        wr_load,
  output logic [21:0] rd_addr,
  output logic [21:0] rd_max_addr,
  output logic        rd_load,
  output logic        frame_valid,
  output logic [1:0]  wr_slot,
  output logic [1:0]  rd_slot,
  output logic [15:0] drop_cnt,
  output logic [15:0] repeat_cnt
);

  localparam int unsigned CW = $clog2(LOAD_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(LOAD_CYCLES - 1);

  // Slot bases built with adds only; wraps mod 2^22 by construction.
  localparam logic [21:0] SLOT1_BASE = BASE_ADDR + FRAME_SIZE;
  localparam logic [21:0] SLOT2_BASE = SLOT1_BASE + FRAME_SIZE;

  typedef enum logic [1:0] {WAIT_INIT, LOAD, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] phase_q, phase_d;
  logic [1:0]    wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d, last_q, last_d;
  logic          unread_q, unread_d, valid_q, valid_d;
  logic [15:0]   drop_q, drop_d, repeat_q, repeat_d;
  logic          wr_load_q, wr_load_d, rd_load_q, rd_load_d;
  logic [CW-1:0] wr_lcnt_q, wr_lcnt_d, rd_lcnt_q, rd_lcnt_d;
  logic [21:0]   wr_addr_q, wr_max_q, rd_addr_q, rd_max_q;

  // Lowest slot index not used by either argument.
  function automatic logic [1:0] lowest_free(input logic [1:0] a, input logic [1:0] b);
    if (a != 2'd0 && b != 2'd0)      return 2'd0;
    else if (a != 2'd1 && b != 2'd1) return 2'd1;
    else                             return 2'd2;
  endfunction

  function automatic logic [21:0] slot_base(input logic [1:0] s);
    case (s)
      2'd0:    return BASE_ADDR;
      2'd1:    return SLOT1_BASE;
      default: return SLOT2_BASE;
    endcase
  endfunction

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d   = state_q;
    phase_d   = phase_q;
    wr_slot_d = wr_slot_q;
    rd_slot_d = rd_slot_q;
    last_d    = last_q;
    unread_d  = unread_q;
    valid_d   = valid_q;
    drop_d    = drop_q;
    repeat_d  = repeat_q;
    wr_load_d = 1'b0;
    rd_load_d = 1'b0;
    wr_lcnt_d = '0;
    rd_lcnt_d = '0;

    case (state_q)
      WAIT_INIT: begin
        if (sdram_init_done) begin
          state_d = LOAD;
          phase_d = '0;
        end
      end
      LOAD: begin
        if (phase_q == LAST_CNT) state_d = RUN;
        else                     phase_d = phase_q + 1'b1;
      end
      default: begin // RUN
        if (frame_write_done && frame_read_done) begin
          // The just-finished frame goes straight to display; the previously
          // displayed slot becomes free, so avoid only the old write slot.
          rd_slot_d = wr_slot_q;
          last_d    = wr_slot_q;
          wr_slot_d = lowest_free(wr_slot_q, wr_slot_q);
          unread_d  = 1'b0;
          valid_d   = 1'b1;
        end else if (frame_write_done) begin
          last_d    = wr_slot_q;
          valid_d   = 1'b1;
          unread_d  = 1'b1;
          if (unread_q && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          wr_slot_d = lowest_free(rd_slot_q, wr_slot_q);
        end else if (frame_read_done) begin
          if (unread_q) begin
            rd_slot_d = last_q;
            unread_d  = 1'b0;
          end else if (valid_q && repeat_q != 16'hFFFF) begin
            repeat_d = repeat_q + 16'd1;
          end
        end
      end
    endcase

    // Losing init overrides everything and re-applies the reset picture.
    if (!sdram_init_done) begin
      state_d   = WAIT_INIT;
      wr_slot_d = 2'd0;
      rd_slot_d = 2'd1;
      last_d    = 2'd1;
      unread_d  = 1'b0;
      valid_d   = 1'b0;
      drop_d    = '0;
      repeat_d  = '0;
    end

    // Outside RUN both strobes stay high. In RUN a slot change (re)starts a
    // LOAD_CYCLES-long pulse; the counter holds the remaining extra cycles.
    if (state_d != RUN) begin
      wr_load_d = 1'b1;
      rd_load_d = 1'b1;
    end else begin
      if (wr_slot_d != wr_slot_q) begin
        wr_load_d = 1'b1;
        wr_lcnt_d = LAST_CNT;
      end else if (wr_lcnt_q != '0) begin
        wr_load_d = 1'b1;
        wr_lcnt_d = wr_lcnt_q - 1'b1;
      end
      if (rd_slot_d != rd_slot_q) begin
        rd_load_d = 1'b1;
        rd_lcnt_d = LAST_CNT;
      end else if (rd_lcnt_q != '0) begin
        rd_load_d = 1'b1;
        rd_lcnt_d = rd_lcnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_INIT;
      phase_q   <= '0;
      wr_slot_q <= 2'd0;
      rd_slot_q <= 2'd1;
      last_q    <= 2'd1;
      unread_q  <= 1'b0;
      valid_q   <= 1'b0;
      drop_q    <= '0;
      repeat_q  <= '0;
      wr_load_q <= 1'b1;
      rd_load_q <= 1'b1;
      wr_lcnt_q <= '0;
      rd_lcnt_q <= '0;
      wr_addr_q <= BASE_ADDR;
      wr_max_q  <= SLOT1_BASE;
      rd_addr_q <= SLOT1_BASE;
      rd_max_q  <= SLOT2_BASE;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge
      // values of the others, independent of statement order.
      state_q   <= state_d;
      phase_q   <= phase_d;
      wr_slot_q <= wr_slot_d;
      rd_slot_q <= rd_slot_d;
      last_q    <= last_d;
      unread_q  <= unread_d;
      valid_q   <= valid_d;
      drop_q    <= drop_d;
      repeat_q  <= repeat_d;
      wr_load_q <= wr_load_d;
      rd_load_q <= rd_load_d;
      wr_lcnt_q <= wr_lcnt_d;
      rd_lcnt_q <= rd_lcnt_d;
      wr_addr_q <= slot_base(wr_slot_d);
      wr_max_q  <= slot_base(wr_slot_d) + FRAME_SIZE;
      rd_addr_q <= slot_base(rd_slot_d);
      rd_max_q  <= slot_base(rd_slot_d) + FRAME_SIZE;
    end
  end

  assign wr_addr     = wr_addr_q;
  assign wr_max_addr = wr_max_q;
  assign wr_load     = wr_load_q;
  assign rd_addr     = rd_addr_q;
  assign rd_max_addr = rd_max_q;
  assign rd_load     = rd_load_q;
  assign frame_valid = valid_q;
  assign wr_slot     = wr_slot_q;
  assign rd_slot     = rd_slot_q;
  assign drop_cnt    = drop_q;
  assign repeat_cnt  = repeat_q;

endmodule

// File: tb/tb_sdram_frame_buf_sched.sv
// -----------------------------------------------------------------------------
// tb_sdram_frame_buf_sched
//   Bench for sdram_frame_buf_sched: directed scenarios with literal
//   expectations followed by randomized done pulses and init drops, with every
//   cycle compared against a slot-bookkeeping model.
// -----------------------------------------------------------------------------
module tb_sdram_frame_buf_sched;

  localparam int L  = 4;
  localparam int FS = 307200;

  logic        clk_ref = 1'b0;
  logic        rst_n;
  logic        sdram_init_done, frame_write_done, frame_read_done;
  logic [21:0] wr_addr, wr_max_addr, rd_addr, rd_max_addr;
  logic        wr_load, rd_load, frame_valid;
  logic [1:0]  wr_slot, rd_slot;
  logic [15:0] drop_cnt, repeat_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_frame_buf_sched dut (
    .clk_ref(clk_ref), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
    .frame_write_done(frame_write_done), .frame_read_done(frame_read_done),
    .wr_addr(wr_addr), .wr_max_addr(wr_max_addr), .wr_load(wr_load),
    .rd_addr(rd_addr), .rd_max_addr(rd_max_addr), .rd_load(rd_load),
    .frame_valid(frame_valid), .wr_slot(wr_slot), .rd_slot(rd_slot),
    .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt)
  );

  always #5 clk_ref = ~clk_ref;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 waiting for init, 1 loading, 2 running
  int m_mode, m_left, m_wr, m_rd, m_last, m_unread, m_valid, m_drop, m_rep;
  int m_wr_age, m_rd_age;

  function automatic int first_not_in(input int a, input int b);
    for (int s = 0; s < 3; s++)
      if (s != a && s != b) return s;
    return -1;
  endfunction

  task automatic model_clear();
    m_mode = 0; m_wr = 0; m_rd = 1; m_last = 1; m_unread = 0; m_valid = 0;
    m_drop = 0; m_rep = 0; m_wr_age = 0; m_rd_age = 0;
  endtask

  always @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n || !sdram_init_done) begin
      model_clear();
    end else if (m_mode == 0) begin
      m_mode = 1;
      m_left = L;
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = 2; m_wr_age = L; m_rd_age = L;
      end
    end else begin
      int ow, orr;
      ow = m_wr; orr = m_rd;
      if (frame_write_done && frame_read_done) begin
        m_rd = ow; m_last = ow; m_wr = first_not_in(ow, ow);
        m_unread = 0; m_valid = 1;
      end else if (frame_write_done) begin
        if (m_unread == 1) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
        m_last = ow; m_unread = 1; m_valid = 1;
        m_wr = first_not_in(m_rd, m_last);
      end else if (frame_read_done) begin
        if (m_unread == 1) begin
          m_rd = m_last; m_unread = 0;
        end else if (m_valid == 1) begin
          m_rep = (m_rep < 65535) ? m_rep + 1 : 65535;
        end
      end
      m_wr_age = (m_wr != ow) ? 0 : (m_wr_age < 1000 ? m_wr_age + 1 : 1000);
      m_rd_age = (m_rd != orr) ? 0 : (m_rd_age < 1000 ? m_rd_age + 1 : 1000);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_ref) begin
    if (rst_n) begin
      check("wr_slot", wr_slot, m_wr);
      check("rd_slot", rd_slot, m_rd);
      check("wr_addr", wr_addr, m_wr * FS);
      check("wr_max_addr", wr_max_addr, m_wr * FS + FS);
      check("rd_addr", rd_addr, m_rd * FS);
      check("rd_max_addr", rd_max_addr, m_rd * FS + FS);
      check("wr_load", wr_load, (m_mode != 2 || m_wr_age < L) ? 1 : 0);
      check("rd_load", rd_load, (m_mode != 2 || m_rd_age < L) ? 1 : 0);
      check("frame_valid", frame_valid, m_valid);
      check("drop_cnt", drop_cnt, m_drop);
      check("repeat_cnt", repeat_cnt, m_rep);
      if (m_mode == 2) begin
        check("wr_ne_rd", (wr_slot != rd_slot) ? 1 : 0, 1);
        check("wr_ne_last", (wr_slot != m_last) ? 1 : 0, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_ref); #1;
  endtask

  task automatic pulse(input logic w, input logic r);
    frame_write_done = w; frame_read_done = r;
    step();
    frame_write_done = 1'b0; frame_read_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int hi;
    rst_n = 1'b0; sdram_init_done = 1'b0;
    frame_write_done = 1'b0; frame_read_done = 1'b0;
    #23 rst_n = 1'b1;

    // 1: reset picture and LOAD length
    idle(8);
    @(negedge clk_ref);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_rd_addr", rd_addr, 307200);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_wr_load", wr_load, 1);
    step();
    sdram_init_done = 1'b1;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_ref);
      if (wr_load && rd_load) hi++;
    end
    check("load_phase_cycles", hi, L + 1); // includes the last WAIT_INIT cycle
    step();

    // 2: first frame written, then read
    pulse(1'b1, 1'b0);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_ref);
      if (wr_load) hi++;
    end
    check("t2_wr_load_len", hi, 4);
    check("t2_wr_slot", wr_slot, 2);
    check("t2_wr_addr", wr_addr, 614400);
    check("t2_frame_valid", frame_valid, 1);
    step();
    pulse(1'b0, 1'b1);
    idle(6);
    check("t2_rd_slot", rd_slot, 0);
    check("t2_rd_addr", rd_addr, 0);
    check("t2_repeat", repeat_cnt, 0);

    // 3: three writes, no read
    for (int i = 0; i < 3; i++) begin pulse(1'b1, 1'b0); idle(2); end
    check("t3_drop", drop_cnt, 2);
    check("t3_wr_slot", wr_slot, 1);

    // 4: consume newest, then two reads with nothing new
    pulse(1'b0, 1'b1); idle(6);
    check("t4_rd_slot", rd_slot, 2);
    pulse(1'b0, 1'b1); idle(1);
    pulse(1'b0, 1'b1); idle(3);
    check("t4_rd_slot_hold", rd_slot, 2);
    check("t4_repeat", repeat_cnt, 2);

    // 5: simultaneous write+read (wr=1, rd=2)
    pulse(1'b1, 1'b1); idle(2);
    check("t5_rd_slot", rd_slot, 1);
    check("t5_wr_slot", wr_slot, 0);
    check("t5_drop", drop_cnt, 2);
    check("t5_repeat", repeat_cnt, 2);

    // 6: init drop mid-pulse, pulses ignored while down
    pulse(1'b1, 1'b0);
    sdram_init_done = 1'b0;
    step();
    pulse(1'b1, 1'b1);
    idle(2);
    check("t6_wr_slot", wr_slot, 0);
    check("t6_rd_slot", rd_slot, 1);
    check("t6_loads", {wr_load, rd_load}, 3);
    check("t6_drop", drop_cnt, 0);
    sdram_init_done = 1'b1;
    idle(L + 3);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      frame_write_done = ($urandom_range(0, 5) == 0);
      frame_read_done  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 399) == 0) sdram_init_done = 1'b0;
      else if (!sdram_init_done && $urandom_range(0, 2) == 0) sdram_init_done = 1'b1;
      step();
    end
    frame_write_done = 1'b0; frame_read_done = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
